// File: rtl/dsi_lane_distributor_pkg.sv
// Shared types and constants for the DSI lane distributor: FSM states,
// the maximum lane count and the per-packet lane-mask helper.
package dsi_pkg;

    localparam int DSI_LANES_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FINISH = 2'd3
    } dsi_state_e;

    // LP packets are single-lane; HS packets use lanes 0..min(num, lanes-1).
    function automatic logic [DSI_LANES_MAX-1:0] lane_mask(
        input logic       lp,
        input logic [1:0] num,
        input int         lanes
    );
        logic [DSI_LANES_MAX-1:0] m;
        int top;
        m   = '0;
        top = lp ? 0 : ((int'(num) < lanes - 1) ? int'(num) : lanes - 1);
        for (int k = 0; k < DSI_LANES_MAX; k++) begin
            m[k] = (k <= top);
        end
        return m;
    endfunction

endpackage

// File: rtl/dsi_lane_distributor_if.sv
// Upstream packet-beat stream into the DSI lane distributor (valid/ready).
interface dsi_lane_distributor_if;
    import dsi_pkg::*;

    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_mode_lp;
    logic        s_ready;

    modport master (output s_data, output s_valid, output s_last,
                    output s_mode_lp, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last,
                    input s_mode_lp, output s_ready);
endinterface

// File: rtl/dsi_lane_distributor.sv
// Splits 32-bit packet beats byte-wise across up to four DSI PHY lanes.
// Optional sticky underrun flag is built when DSI_DISTRIB_UNDERRUN_EN is defined.
module dsi_lane_distributor
    import dsi_pkg::*;
#(
    parameter int LANES_MAX = DSI_LANES_MAX
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic                   cfg_lanes_en,
    input  logic [1:0]             cfg_lanes_num,
    dsi_lane_distributor_if.slave  src,
    input  logic [LANES_MAX-1:0]   lane_data_rqst,
    input  logic [LANES_MAX-1:0]   lane_active,
    output logic                   lanes_enable,
    output logic                   lane_mode_lp,
    output logic [LANES_MAX-1:0]   lane_start_rqst,
    output logic [LANES_MAX-1:0]   lane_fin_rqst,
    output logic [8*LANES_MAX-1:0] lane_data,
    output logic                   pkt_done
`ifdef DSI_DISTRIB_UNDERRUN_EN
    ,
    output logic                   err_underrun,
    input  logic                   err_clr
`endif
);

    dsi_state_e               state_r;
    dsi_state_e               state_nxt_s;
    logic [31:0]              hold_data_r;
    logic                     hold_last_r;
    logic                     hold_vld_r;
    logic [LANES_MAX-1:0]     mask_r;
    logic [DSI_LANES_MAX-1:0] mask_new_s;
    logic                     lanes_enable_r;
    logic                     mode_lp_r;
    logic                     s_ready_s;
    logic                     load_s;
    logic                     consume_s;
    logic                     start_s;
    logic                     pkt_done_s;
    logic                     all_rqst_s;

    assign mask_new_s = lane_mask(src.s_mode_lp, cfg_lanes_num, LANES_MAX);
    assign all_rqst_s = ((lane_data_rqst & mask_r) == mask_r);

    // Next-state and handshake decode.
    always_comb begin
        state_nxt_s = state_r;
        s_ready_s   = 1'b0;
        load_s      = 1'b0;
        consume_s   = 1'b0;
        start_s     = 1'b0;
        pkt_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (src.s_valid && lanes_enable_r && (lane_active == '0)) begin
                    s_ready_s   = 1'b1;
                    load_s      = 1'b1;
                    start_s     = 1'b1;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_nxt_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (hold_vld_r) begin
                    if (all_rqst_s) begin
                        consume_s = 1'b1;
                        if (hold_last_r) begin
                            state_nxt_s = ST_FINISH;
                        end else begin
                            s_ready_s = 1'b1;
                            load_s    = src.s_valid;
                        end
                    end else begin
                        state_nxt_s = ST_STREAM;
                    end
                end else begin
                    // Hold register drained mid-packet: keep asking upstream.
                    s_ready_s = 1'b1;
                    load_s    = src.s_valid;
                end
            end
            ST_FINISH: begin
                if ((lane_active & mask_r) == '0) begin
                    pkt_done_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FINISH;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Beat hold register; a reload in the consume cycle keeps it valid.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_r <= 32'h0000_0000;
            hold_last_r <= 1'b0;
            hold_vld_r  <= 1'b0;
        end else if (load_s) begin
            hold_data_r <= src.s_data;
            hold_last_r <= src.s_last;
            hold_vld_r  <= 1'b1;
        end else if (consume_s) begin
            hold_vld_r  <= 1'b0;
        end else begin
            hold_vld_r  <= hold_vld_r;
        end
    end

    // Per-packet lane mask and mode, frozen from the IDLE-to-START cycle.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            mask_r    <= '0;
            mode_lp_r <= 1'b0;
        end else if (start_s) begin
            mask_r    <= mask_new_s[LANES_MAX-1:0];
            mode_lp_r <= src.s_mode_lp;
        end else begin
            mask_r    <= mask_r;
            mode_lp_r <= mode_lp_r;
        end
    end

    // Lane enable follows configuration only between packets.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            lanes_enable_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            lanes_enable_r <= cfg_lanes_en;
        end else begin
            lanes_enable_r <= lanes_enable_r;
        end
    end

    assign src.s_ready      = s_ready_s;
    assign lanes_enable     = lanes_enable_r;
    assign lane_mode_lp     = mode_lp_r;
    assign pkt_done         = pkt_done_s;
    assign lane_start_rqst  = (state_r == ST_START) ? mask_r : '0;
    assign lane_fin_rqst    = mask_r & {LANES_MAX{hold_vld_r && hold_last_r}};

    for (genvar k = 0; k < LANES_MAX; k++) begin : g_lane
        assign lane_data[8*k +: 8] = mask_r[k] ? hold_data_r[8*k +: 8] : 8'h00;
    end

`ifdef DSI_DISTRIB_UNDERRUN_EN
    logic err_underrun_r;

    // Sticky underrun: an enabled lane asks for data while the hold is empty.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            err_underrun_r <= 1'b0;
        end else if ((state_r == ST_STREAM) && !hold_vld_r &&
                     ((lane_data_rqst & mask_r) != '0)) begin
            err_underrun_r <= 1'b1;
        end else if (err_clr) begin
            err_underrun_r <= 1'b0;
        end else begin
            err_underrun_r <= err_underrun_r;
        end
    end

    assign err_underrun = err_underrun_r;
`endif

endmodule

// File: tb/tb_dsi_lane_distributor.sv
// Randomized self-checking bench for dsi_lane_distributor against a
// packet-level model of lane masks, per-lane bytes, handshakes and pkt_done.
module tb_dsi_lane_distributor;

    logic        clk_sys;
    logic        rst_n;
    logic        cfg_lanes_en;
    logic [1:0]  cfg_lanes_num;
    logic [3:0]  lane_data_rqst;
    logic [3:0]  lane_active;
    logic        lanes_enable;
    logic        lane_mode_lp;
    logic [3:0]  lane_start_rqst;
    logic [3:0]  lane_fin_rqst;
    logic [31:0] lane_data;
    logic        pkt_done;
`ifdef DSI_DISTRIB_UNDERRUN_EN
    logic        err_underrun;
    logic        err_clr;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    logic [31:0] beats[$];

    dsi_lane_distributor_if sif();

    dsi_lane_distributor #(.LANES_MAX(4)) dut (
        .clk_sys         (clk_sys),
        .rst_n           (rst_n),
        .cfg_lanes_en    (cfg_lanes_en),
        .cfg_lanes_num   (cfg_lanes_num),
        .src             (sif),
        .lane_data_rqst  (lane_data_rqst),
        .lane_active     (lane_active),
        .lanes_enable    (lanes_enable),
        .lane_mode_lp    (lane_mode_lp),
        .lane_start_rqst (lane_start_rqst),
        .lane_fin_rqst   (lane_fin_rqst),
        .lane_data       (lane_data),
        .pkt_done        (pkt_done)
`ifdef DSI_DISTRIB_UNDERRUN_EN
        ,
        .err_underrun    (err_underrun),
        .err_clr         (err_clr)
`endif
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Plays source and PHY lanes for one packet held in beats[].
    task automatic run_packet(input bit lp, input logic [1:0] num, input int vprob,
                              input bit gap_en, input bit drop_en);
        int nb, si, cons, phase, fin_wait, gap_cnt, cnt, top, budget;
        int dly[4];
        logic [3:0]  mask, rq, act;
        logic [31:0] bmask;
        bit hs;
        nb = beats.size();
        si = 0; cons = 0; phase = 0; fin_wait = 0; cnt = 0; budget = 0;
        gap_cnt = gap_en ? 5 : 0;
        top  = lp ? 0 : ((int'(num) < 3) ? int'(num) : 3);
        mask = 4'((1 << (top + 1)) - 1);
        for (int k = 0; k < 4; k++) begin
            bmask[8*k +: 8] = {8{mask[k]}};
            dly[k] = $urandom_range(0, 3);
        end
        while (phase != 3 && budget < 3000) begin
            @(negedge clk_sys);
            budget++;
            if (si < nb && !(gap_en && si == 1 && gap_cnt > 0) &&
                $urandom_range(1, 100) <= vprob) begin
                sif.s_valid = 1'b1;
                sif.s_data  = beats[si];
                sif.s_last  = (si == nb - 1);
            end else begin
                sif.s_valid = 1'b0;
                sif.s_data  = $urandom;
                sif.s_last  = 1'($urandom);
            end
            sif.s_mode_lp = (si == 0) ? lp : 1'($urandom);
            cfg_lanes_num = (phase == 0) ? num : 2'($urandom);
            if (drop_en && phase != 0) cfg_lanes_en = 1'b0;
            rq = 4'($urandom) & ~mask;
            if (phase == 1) begin
                if (si > cons) begin
                    for (int k = 0; k < 4; k++)
                        if (mask[k] && cnt >= dly[k]) rq[k] = 1'b1;
                end else if (gap_cnt > 0) begin
                    rq = rq | mask;
                end
            end
            lane_data_rqst = rq;
            act = (phase == 1 || (phase == 2 && fin_wait > 0)) ? mask : 4'h0;
            lane_active = act;
            #1;
            hs = sif.s_valid && sif.s_ready;
            chk("pkt_done", {31'd0, pkt_done}, {31'd0, (phase == 2 && act == 4'h0)});
            if (phase == 0) begin
                if (lane_start_rqst != 4'h0) begin
                    chk("start_mask", {28'd0, lane_start_rqst}, {28'd0, mask});
                    chk("mode_lp", {31'd0, lane_mode_lp}, {31'd0, lp});
                    phase = 1;
                    cnt = 0;
                end
            end else if (phase == 1) begin
                chk("lanes_enable", {31'd0, lanes_enable}, 32'd1);
                if (si > cons && (rq & mask) == mask) begin
                    chk("lane_data", lane_data, beats[cons] & bmask);
                    chk("lane_fin", {28'd0, lane_fin_rqst},
                        (cons == nb - 1) ? {28'd0, mask} : 32'd0);
                    chk("consume_rdy", {31'd0, sif.s_ready}, {31'd0, (cons != nb - 1)});
                    cons++;
                    cnt = 0;
                    for (int k = 0; k < 4; k++) dly[k] = $urandom_range(0, 3);
                    if (cons == nb) begin
                        phase = 2;
                        fin_wait = $urandom_range(0, 4);
                    end
                end else if (si > cons) begin
                    chk("stall_rdy", {31'd0, sif.s_ready}, 32'd0);
                    cnt++;
                end else begin
                    chk("gap_rdy", {31'd0, sif.s_ready}, 32'd1);
                    if (gap_cnt > 0) gap_cnt--;
                end
            end else begin
                if (act == 4'h0) phase = 3;
                else fin_wait--;
            end
            if (hs) si++;
        end
        if (phase != 3) chk("pkt_timeout", phase, 32'd3);
        chk("beats_taken", si, nb);
        sif.s_valid    = 1'b0;
        lane_data_rqst = 4'h0;
        lane_active    = 4'h0;
    endtask

    initial begin
        bit lp;
        int nb, t;
        rst_n = 1'b0; cfg_lanes_en = 1'b0; cfg_lanes_num = 2'd0;
        lane_data_rqst = 4'h0; lane_active = 4'h0;
        sif.s_valid = 1'b0; sif.s_data = 32'h0; sif.s_last = 1'b0; sif.s_mode_lp = 1'b0;
`ifdef DSI_DISTRIB_UNDERRUN_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(negedge clk_sys);
        #1;
        chk("rst_ready", {31'd0, sif.s_ready}, 32'd0);
        chk("rst_en", {31'd0, lanes_enable}, 32'd0);
        chk("rst_start", {28'd0, lane_start_rqst}, 32'd0);
        chk("rst_data", lane_data, 32'd0);
        chk("rst_done", {31'd0, pkt_done}, 32'd0);

        // Lanes disabled: a valid beat must not be accepted.
        @(negedge clk_sys);
        rst_n = 1'b1;
        sif.s_valid = 1'b1; sif.s_data = 32'h12345678; sif.s_last = 1'b1;
        repeat (3) begin
            @(negedge clk_sys);
            #1;
            chk("dis_ready", {31'd0, sif.s_ready}, 32'd0);
            chk("dis_en", {31'd0, lanes_enable}, 32'd0);
        end
        sif.s_valid = 1'b0;
        cfg_lanes_en = 1'b1;
        repeat (2) @(negedge clk_sys);
        #1;
        chk("en_on", {31'd0, lanes_enable}, 32'd1);

        beats = '{32'h03020100, 32'h07060504, 32'h0B0A0988};
        run_packet(1'b0, 2'd3, 100, 1'b0, 1'b0);

        beats = '{32'h000000AA};
        run_packet(1'b1, 2'd3, 100, 1'b0, 1'b0);

`ifdef DSI_DISTRIB_UNDERRUN_EN
        @(negedge clk_sys);
        #1;
        chk("underrun_clean", {31'd0, err_underrun}, 32'd0);
`endif
        beats = '{32'hA1B2C3D4, 32'h5E6F7081, 32'h92A3B4C5};
        run_packet(1'b0, 2'd3, 100, 1'b1, 1'b0);
`ifdef DSI_DISTRIB_UNDERRUN_EN
        @(negedge clk_sys);
        #1;
        chk("underrun_set", {31'd0, err_underrun}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk_sys);
        err_clr = 1'b0;
        #1;
        chk("underrun_clr", {31'd0, err_underrun}, 32'd0);
`endif

        // Disable mid-packet only lands after pkt_done.
        beats = '{32'hCAFEF00D, 32'h0BADBEEF};
        run_packet(1'b0, 2'd1, 80, 1'b0, 1'b1);
        repeat (2) @(negedge clk_sys);
        #1;
        chk("en_off_late", {31'd0, lanes_enable}, 32'd0);
        cfg_lanes_en = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Reset in the middle of a packet.
        beats = '{32'h11223344, 32'h55667788};
        @(negedge clk_sys);
        sif.s_valid = 1'b1; sif.s_data = beats[0]; sif.s_last = 1'b0;
        sif.s_mode_lp = 1'b0; cfg_lanes_num = 2'd3;
        t = 0;
        do begin
            @(negedge clk_sys);
            #1;
            t++;
        end while (lane_start_rqst == 4'h0 && t < 20);
        chk("rst_mid_start", {28'd0, lane_start_rqst}, 32'hF);
        @(negedge clk_sys);
        sif.s_valid = 1'b0; lane_active = 4'hF;
        @(negedge clk_sys);
        rst_n = 1'b0;
        lane_active = 4'h0;
        #1;
        chk("rstm_ready", {31'd0, sif.s_ready}, 32'd0);
        chk("rstm_en", {31'd0, lanes_enable}, 32'd0);
        chk("rstm_mode", {31'd0, lane_mode_lp}, 32'd0);
        chk("rstm_start", {28'd0, lane_start_rqst}, 32'd0);
        chk("rstm_fin", {28'd0, lane_fin_rqst}, 32'd0);
        chk("rstm_data", lane_data, 32'd0);
        chk("rstm_done", {31'd0, pkt_done}, 32'd0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk_sys);
            #1;
            chk("rstm_no_done", {31'd0, pkt_done}, 32'd0);
        end
        beats = '{32'hDEADBEEF, 32'h01234567};
        run_packet(1'b0, 2'd3, 100, 1'b0, 1'b0);

        for (int p = 0; p < 15; p++) begin
            lp = 1'($urandom);
            nb = $urandom_range(1, 4);
            beats.delete();
            repeat (nb) beats.push_back($urandom);
            run_packet(lp, 2'($urandom), $urandom_range(40, 100), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
